// File: rtl/seg_scan.sv
// seg_scan: four-digit common-anode seven-segment multiplexer with a per-frame
// input snapshot and a blanking gap at the start of every digit slot.
`default_nettype none

module seg_scan #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] i_disp,
  input  logic [3:0]  i_dp,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dpo
);

  localparam int             CW     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  c_last = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [19:0]   r_dword;
  logic [3:0]    r_dword_dp;

  logic          w_wrap;
  logic          w_frame;
  logic [CW-1:0] w_cnt_nx;
  logic [1:0]    w_idx_nx;
  logic [19:0]   w_dword_nx;
  logic [3:0]    w_dp_nx;
  logic [4:0]    w_code;
  logic          w_blank;

  function automatic logic [6:0] f_font(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'h3F;
      5'd1:    s = 7'h06;
      5'd2:    s = 7'h5B;
      5'd3:    s = 7'h4F;
      5'd4:    s = 7'h66;
      5'd5:    s = 7'h6D;
      5'd6:    s = 7'h7D;
      5'd7:    s = 7'h07;
      5'd8:    s = 7'h7F;
      5'd9:    s = 7'h6F;
      5'd10:   s = 7'h77;
      5'd11:   s = 7'h7C;
      5'd12:   s = 7'h39;
      5'd13:   s = 7'h5E;
      5'd14:   s = 7'h79;
      5'd15:   s = 7'h71;
      5'd16:   s = 7'h76;
      5'd17:   s = 7'h38;
      5'd18:   s = 7'h73;
      5'd19:   s = 7'h5C;
      5'd20:   s = 7'h50;
      5'd21:   s = 7'h54;
      5'd22:   s = 7'h3E;
      5'd23:   s = 7'h40;
      5'd24:   s = 7'h08;
      5'd25:   s = 7'h78;
      5'd26:   s = 7'h6E;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Outputs are registered from next-state values so they line up with the counters.
  assign w_wrap     = (r_cnt == c_last);
  assign w_frame    = w_wrap && (r_idx == 2'd3);
  assign w_cnt_nx   = w_wrap ? '0 : r_cnt + 1'b1;
  assign w_idx_nx   = w_wrap ? r_idx + 2'd1 : r_idx;
  assign w_dword_nx = w_frame ? i_disp : r_dword;
  assign w_dp_nx    = w_frame ? i_dp : r_dword_dp;

  always_comb begin
    w_code = w_dword_nx[4:0];
    case (w_idx_nx)
      2'd0: w_code = w_dword_nx[4:0];
      2'd1: w_code = w_dword_nx[9:5];
      2'd2: w_code = w_dword_nx[14:10];
      2'd3: w_code = w_dword_nx[19:15];
      default: w_code = w_dword_nx[4:0];
    endcase
  end

  generate
    if (BLANK > 0) begin : g_blank_on
      assign w_blank = (32'(w_cnt_nx) < 32'(BLANK));
    end else begin : g_blank_off
      assign w_blank = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= 2'd0;
      r_dword    <= 20'hFFFFF;
      r_dword_dp <= 4'b0000;
      o_an       <= 4'b1111;
      o_seg      <= 7'h7F;
      o_dpo      <= 1'b1;
    end else begin
      r_cnt      <= w_cnt_nx;
      r_idx      <= w_idx_nx;
      r_dword    <= w_dword_nx;
      r_dword_dp <= w_dp_nx;
      if (w_blank) begin
        o_an  <= 4'b1111;
        o_seg <= 7'h7F;
        o_dpo <= 1'b1;
      end else begin
        o_an  <= ~(4'b0001 << w_idx_nx);
        o_seg <= ~f_font(w_code);
        o_dpo <= ~w_dp_nx[w_idx_nx];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/seg_scan.md
# seg_scan

Four-digit, seven-segment multiplex driver that sits directly downstream of the mode manager. It consumes the manager's 20-bit `disp` word (four 5-bit glyph codes) plus per-digit decimal-point flags. It time-multiplexes them onto a common-anode display with active-low anode and segment lines. The block snapshots the input once per frame so a digit never tears mid-frame, and it inserts a blanking gap at every digit change to suppress ghosting.

## Interface
- `DIV`, default 50000: clock cycles per digit slot. Legal range is `DIV >= BLANK + 2`.
- `BLANK`, default 16: cycles at the start of each slot during which all anodes are off. Legal range is `BLANK >= 0`.
- `clk`  in  1: system clock, the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `disp`  in  20: glyph codes. `disp[4:0]` is digit 0 (rightmost) and `disp[19:15]` is digit 3 (leftmost).
- `dp`  in  4: decimal-point request per digit, 1 = lit. `dp[0]` maps to digit 0.
- `an`  out  4: anode enables, active-low. `an[i]` drives digit i.
- `seg`  out  7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dpo`  out  1: decimal-point segment, active-low.

## Operation
- Slot counter `cnt` counts 0..DIV-1. Digit index `idx` counts 0..3.
- When `cnt == DIV-1`: `cnt` goes to 0 and `idx` goes to `(idx+1) mod 4`.
- Frame latch: on the edge where `idx` goes 3→0 (`cnt == DIV-1 && idx == 3`), register `disp` into `dword` and `dp` into `dword_dp`. Inputs are ignored at all other times.
- Blanking: while `cnt < BLANK`, drive `an = 4'b1111`, `seg = 7'h7F`, `dpo = 1`.
- Active part of slot (`cnt >= BLANK`):
  - `an = ~(4'b0001 << idx)`.
  - `seg = ~decode(dword[5*idx +: 5])`.
  - `dpo = ~dword_dp[idx]`.
- Decode table, active-high `{g..a}`:
  - 0..9: decimal digits.
  - 10..15: A, b, C, d, E, F.
  - 16: H, 17: L, 18: P, 19: o, 20: r, 21: n, 22: U, 23: `-` (g only), 24: `_` (d only), 25: t, 26: y.
  - 27..31: blank (7'h00).
- Reset state:
  - `cnt = 0`, `idx = 0`.
  - `dword = 20'hFFFFF` (all code 31, blank), `dword_dp = 0`.
  - `an = 4'b1111`, `seg = 7'h7F`, `dpo = 1`.
- The first frame after reset therefore displays blank. Live data appears from the second frame, i.e. 4·DIV cycles after reset release.
- Reset asserted mid-slot: all outputs are forced to their reset values immediately (asynchronous), and counters restart from 0.

## Timing
- `an`, `seg` and `dpo` are flop outputs with no combinational path from any input.
- During a cycle in which the registered counters hold (`cnt = c`, `idx = i`), the outputs show the function of (c, i, `dword`) defined above. This is achieved by computing outputs from next-state values.
- The frame latch and the outputs for slot 0 of the new frame take effect on the same edge. Slot 0 is blank for its first BLANK cycles in any case.
- Input-to-display latency: from 1 to 4·DIV cycles after a `disp` change, depending on frame phase. Any `disp` change inside a frame is not visible until the next frame.
- Exactly one anode is low in any cycle, or none during blanking. There is never overlap between consecutive digits.
- Full frame period is 4·DIV cycles. With the default of 50 MHz / 200000, the refresh rate is 250 Hz.
- With `BLANK = 0`, no blank cycles occur and digits switch on the slot edge.

## Test plan
- Reset, then release with `DIV=8`, `BLANK=2`, `disp=20'h00000`. Required response:
  - First 32 cycles: `seg = 7'h7F`.
  - From cycle 32: slot 0 shows `an` = 1111 for 2 cycles, then `an = 1110` and `seg = 7'b1000000` (digit "0") for 6 cycles.
  - Then `an = 1101`, and so on.
- `disp = {5'd16,5'd14,5'd17,5'd0}` (H E L 0) and `dp = 4'b0100`. Required response over one frame:
  - `seg` is 7'b1000000, 7'b1000111, 7'b0000110, 7'b0001001 for `idx` 0..3.
  - `dpo = 0` only while `an = 1011`.
- Change `disp` at `idx = 2`, mid-frame. Required response: the displayed digits do not change until the next `idx` 3→0 wrap, then all four update together.
- Codes 27..31 on all digits. Required response: `seg = 7'h7F` in every active slot, while `an` still scans normally.
- Assert `rst` for 1 cycle in the middle of `idx = 2`. Required response:
  - `an = 1111` and `seg = 7'h7F` immediately, asynchronously.
  - Scan restarts at `idx = 0` with the blank frame.
- Check `BLANK = 0` and `DIV = 2` as edge parameters. Required response: the anode pattern cycles 1110, 1101, 1011, 0111, each held 2 cycles, with no all-off cycles and never two anodes low at once.
